// File: rtl/nms_sequencer_if.sv
// rtl/nms_sequencer_if.sv - NMS sequencer register, box-buffer, kept-memory and IoU bus
interface nms_sequencer_if #(
    parameter int BBOX_DATA_WIDTH  = 64,
    parameter int BBOX_IND_WIDTH   = 14,
    parameter int IOU_THRESH_WIDTH = 16,
    parameter int S_WIDTH          = 16,
    parameter int MEM_ADDR_WIDTH   = 10
) ();
    logic                        start;
    logic [BBOX_IND_WIDTH-1:0]   num_pred;
    logic [IOU_THRESH_WIDTH-1:0] iou_thresh;
    logic [S_WIDTH-1:0]          S_thresh;
    logic                        pbox_ren;
    logic [BBOX_IND_WIDTH-1:0]   pbox_raddr;
    logic [BBOX_DATA_WIDTH-1:0]  pred_bbox;
    logic                        keep_ren;
    logic [MEM_ADDR_WIDTH-1:0]   keep_raddr;
    logic [BBOX_DATA_WIDTH-1:0]  keep_rdata;
    logic                        keep_wren;
    logic [BBOX_DATA_WIDTH-1:0]  keep_wdata;
    logic                        iou_req_valid;
    logic                        iou_req_ready;
    logic [BBOX_DATA_WIDTH-1:0]  iou_box_a;
    logic [BBOX_DATA_WIDTH-1:0]  iou_box_b;
    logic                        iou_rsp_valid;
    logic [IOU_THRESH_WIDTH-1:0] iou_rsp_value;
    logic [MEM_ADDR_WIDTH-1:0]   bbox_raddr;
    logic                        num_box_wren;
    logic                        busy;
    logic                        done;
    logic                        overflow;

    modport master (
        input  start, num_pred, iou_thresh, S_thresh, pred_bbox, keep_rdata,
               iou_req_ready, iou_rsp_valid, iou_rsp_value,
        output pbox_ren, pbox_raddr, keep_ren, keep_raddr, keep_wren, keep_wdata,
               iou_req_valid, iou_box_a, iou_box_b, bbox_raddr, num_box_wren,
               busy, done, overflow
    );

    modport slave (
        output start, num_pred, iou_thresh, S_thresh, pred_bbox, keep_rdata,
               iou_req_ready, iou_rsp_valid, iou_rsp_value,
        input  pbox_ren, pbox_raddr, keep_ren, keep_raddr, keep_wren, keep_wdata,
               iou_req_valid, iou_box_a, iou_box_b, bbox_raddr, num_box_wren,
               busy, done, overflow
    );
endinterface

// File: rtl/nms_sequencer.sv
// rtl/nms_sequencer.sv - greedy non-maximum suppression control FSM
module nms_sequencer #(
    parameter int BBOX_DATA_WIDTH  = 64,
    parameter int BBOX_IND_WIDTH   = 14,
    parameter int IOU_THRESH_WIDTH = 16,
    parameter int S_WIDTH          = 16,
    parameter int MEM_ADDR_WIDTH   = 10
) (
    input  logic              clk,
    input  logic              gen_rst,
    nms_sequencer_if.master   bus
);
    localparam logic [MEM_ADDR_WIDTH-1:0] KEEP_MAX = {MEM_ADDR_WIDTH{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_CHECK, S_KRD, S_REQ, S_WAIT, S_WRITE, S_NEXT, S_FIN
    } state_t;

    state_t                      state_q, state_d;
    logic                        start_q;
    logic [BBOX_IND_WIDTH-1:0]   i_q, i_d, num_pred_q, num_pred_d;
    logic [MEM_ADDR_WIDTH-1:0]   j_q, j_d, count_q, count_d;
    logic [BBOX_DATA_WIDTH-1:0]  cand_q, cand_d, boxb_q, boxb_d;
    logic                        rd_pend_q, rd_pend_d;
    logic [IOU_THRESH_WIDTH-1:0] iou_thr_q, iou_thr_d;
    logic [S_WIDTH-1:0]          s_thr_q, s_thr_d;
    logic                        busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic                        pbox_ren, keep_ren, keep_wren, iou_req_valid, num_box_wren;

    always_ff @(posedge clk or posedge gen_rst) begin
        if (gen_rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            i_q        <= '0;
            num_pred_q <= '0;
            j_q        <= '0;
            count_q    <= '0;
            cand_q     <= '0;
            boxb_q     <= '0;
            rd_pend_q  <= 1'b0;
            iou_thr_q  <= '0;
            s_thr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus.start;
            i_q        <= i_d;
            num_pred_q <= num_pred_d;
            j_q        <= j_d;
            count_q    <= count_d;
            cand_q     <= cand_d;
            boxb_q     <= boxb_d;
            rd_pend_q  <= rd_pend_d;
            iou_thr_q  <= iou_thr_d;
            s_thr_q    <= s_thr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        num_pred_d    = num_pred_q;
        j_d           = j_q;
        count_d       = count_q;
        cand_d        = cand_q;
        boxb_d        = boxb_q;
        rd_pend_d     = rd_pend_q;
        iou_thr_d     = iou_thr_q;
        s_thr_d       = s_thr_q;
        busy_d        = busy_q;
        done_d        = done_q;
        ovf_d         = ovf_q;
        pbox_ren      = 1'b0;
        keep_ren      = 1'b0;
        keep_wren     = 1'b0;
        iou_req_valid = 1'b0;
        num_box_wren  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !start_q) begin
                    num_pred_d = bus.num_pred;
                    iou_thr_d  = bus.iou_thresh;
                    s_thr_d    = bus.S_thresh;
                    count_d    = '0;
                    i_d        = '0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (bus.num_pred == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                pbox_ren = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                cand_d = bus.pred_bbox;
                if (bus.pred_bbox[BBOX_DATA_WIDTH-1 -: S_WIDTH] < s_thr_q) begin
                    state_d = S_NEXT;
                end else if (count_q == KEEP_MAX) begin
                    ovf_d   = 1'b1;
                    state_d = S_NEXT;
                end else if (count_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    j_d     = '0;
                    state_d = S_KRD;
                end
            end
            S_KRD: begin
                keep_ren  = 1'b1;
                rd_pend_d = 1'b1;
                state_d   = S_REQ;
            end
            S_REQ: begin
                // Kept word arrives in the first REQ cycle; capture it so box_b holds through a stall.
                iou_req_valid = 1'b1;
                if (rd_pend_q) begin
                    boxb_d    = bus.keep_rdata;
                    rd_pend_d = 1'b0;
                end
                if (bus.iou_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.iou_rsp_valid) begin
                    if (bus.iou_rsp_value > iou_thr_q) begin
                        state_d = S_NEXT;
                    end else if (j_q == count_q - 1'b1) begin
                        state_d = S_WRITE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = S_KRD;
                    end
                end
            end
            S_WRITE: begin
                keep_wren = 1'b1;
                count_d   = count_q + 1'b1;
                state_d   = S_NEXT;
            end
            S_NEXT: begin
                if (i_q == num_pred_q - 1'b1) begin
                    state_d = S_FIN;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FIN: begin
                num_box_wren = 1'b1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.pbox_ren      = pbox_ren;
    assign bus.pbox_raddr    = i_q;
    assign bus.keep_ren      = keep_ren;
    assign bus.keep_raddr    = j_q;
    assign bus.keep_wren     = keep_wren;
    assign bus.keep_wdata    = cand_q;
    assign bus.iou_req_valid = iou_req_valid;
    assign bus.iou_box_a     = cand_q;
    assign bus.iou_box_b     = rd_pend_q ? bus.keep_rdata : boxb_q;
    assign bus.bbox_raddr    = count_q;
    assign bus.num_box_wren  = num_box_wren;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.overflow      = ovf_q;
endmodule
